// File: rtl/ahb_sync_mc.sv
// ahb_sync_mc: per-channel req/ack synchronisers with holding slots,
// drained round-robin onto one valid/take register port in HCLK.
module ahb_sync_mc #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int DLEN_WIDTH  = 2,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] DADR,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] CADR,
    input  logic [NUM_CH*DLEN_WIDTH-1:0] DLEN,
    output logic [NUM_CH-1:0]            ack,
    output logic                         REGs_ready,
    input  logic                         regs_take,
    output logic [ADDR_WIDTH-1:0]        DADR_O,
    output logic [ADDR_WIDTH-1:0]        CADR_O,
    output logic [DLEN_WIDTH-1:0]        DLEN_O,
    output logic [CH_W-1:0]              CH_O
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACKD = 1'b1
    } ch_state_e;

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
    logic [NUM_CH-1:0]      sreq;

    ch_state_e state_q [NUM_CH];
    ch_state_e state_d [NUM_CH];

    logic [NUM_CH-1:0] cap;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;

    logic [ADDR_WIDTH-1:0] slot_dadr_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] slot_dadr_d [NUM_CH];
    logic [ADDR_WIDTH-1:0] slot_cadr_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] slot_cadr_d [NUM_CH];
    logic [DLEN_WIDTH-1:0] slot_dlen_q [NUM_CH];
    logic [DLEN_WIDTH-1:0] slot_dlen_d [NUM_CH];

    logic                  ready_q;
    logic                  ready_d;
    logic [ADDR_WIDTH-1:0] dadr_o_q;
    logic [ADDR_WIDTH-1:0] dadr_o_d;
    logic [ADDR_WIDTH-1:0] cadr_o_q;
    logic [ADDR_WIDTH-1:0] cadr_o_d;
    logic [DLEN_WIDTH-1:0] dlen_o_q;
    logic [DLEN_WIDTH-1:0] dlen_o_d;
    logic [CH_W-1:0]       ch_o_q;
    logic [CH_W-1:0]       ch_o_d;
    logic [CH_W-1:0]       rr_q;
    logic [CH_W-1:0]       rr_d;

    logic            gnt_found;
    logic [CH_W-1:0] gnt_idx;
    logic            load;

    // Shift each foreign req into its synchroniser chain
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], req[i]};
        end
    end

    // Only the last synchroniser stage is trusted
    always_comb begin
        sreq = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sreq[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Per-channel handshake FSM; capture only into a free slot
    always_comb begin
        cap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                S_IDLE: begin
                    if (sreq[i] && !pend_q[i]) begin
                        state_d[i] = S_ACKD;
                        cap[i]     = 1'b1;
                    end
                end
                S_ACKD: begin
                    if (!sreq[i]) begin
                        state_d[i] = S_IDLE;
                    end
                end
            endcase
        end
    end

    // The acknowledge level is the registered FSM state itself
    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ack[i] = (state_q[i] == S_ACKD);
        end
    end

    // Holding slots sample the channel fields on the capture edge
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            slot_dadr_d[i] = slot_dadr_q[i];
            slot_cadr_d[i] = slot_cadr_q[i];
            slot_dlen_d[i] = slot_dlen_q[i];
            if (cap[i]) begin
                slot_dadr_d[i] = DADR[i*ADDR_WIDTH +: ADDR_WIDTH];
                slot_cadr_d[i] = CADR[i*ADDR_WIDTH +: ADDR_WIDTH];
                slot_dlen_d[i] = DLEN[i*DLEN_WIDTH +: DLEN_WIDTH];
            end
        end
    end

    // Round-robin search: first pending slot at or after rr_q
    always_comb begin
        int j;
        logic [CH_W-1:0] idx;
        j         = 0;
        idx       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            idx = CH_W'(j);
            if (!gnt_found && pend_q[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Output register load, drain and pointer advance
    always_comb begin
        load     = (!ready_q || regs_take) && gnt_found;
        clr      = '0;
        ready_d  = ready_q;
        dadr_o_d = dadr_o_q;
        cadr_o_d = cadr_o_q;
        dlen_o_d = dlen_o_q;
        ch_o_d   = ch_o_q;
        rr_d     = rr_q;
        if (load) begin
            clr[gnt_idx] = 1'b1;
            ready_d      = 1'b1;
            dadr_o_d     = slot_dadr_q[gnt_idx];
            cadr_o_d     = slot_cadr_q[gnt_idx];
            dlen_o_d     = slot_dlen_q[gnt_idx];
            ch_o_d       = gnt_idx;
            if (int'(gnt_idx) == NUM_CH - 1) begin
                rr_d = '0;
            end else begin
                rr_d = gnt_idx + 1'b1;
            end
        end else if (regs_take) begin
            ready_d = 1'b0;
        end
    end

    // Grant and capture never hit the same slot in one cycle
    always_comb begin
        pend_d = (pend_q & ~clr) | cap;
    end

    // Synchroniser, FSM and holding-slot state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sync_q[i]      <= '0;
                state_q[i]     <= S_IDLE;
                slot_dadr_q[i] <= '0;
                slot_cadr_q[i] <= '0;
                slot_dlen_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                sync_q[i]      <= sync_d[i];
                state_q[i]     <= state_d[i];
                slot_dadr_q[i] <= slot_dadr_d[i];
                slot_cadr_q[i] <= slot_cadr_d[i];
                slot_dlen_q[i] <= slot_dlen_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Output port registers and arbitration pointer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ready_q  <= 1'b0;
            dadr_o_q <= '0;
            cadr_o_q <= '0;
            dlen_o_q <= '0;
            ch_o_q   <= '0;
            rr_q     <= '0;
        end else begin
            ready_q  <= ready_d;
            dadr_o_q <= dadr_o_d;
            cadr_o_q <= cadr_o_d;
            dlen_o_q <= dlen_o_d;
            ch_o_q   <= ch_o_d;
            rr_q     <= rr_d;
        end
    end

    assign REGs_ready = ready_q;
    assign DADR_O     = dadr_o_q;
    assign CADR_O     = cadr_o_q;
    assign DLEN_O     = dlen_o_q;
    assign CH_O       = ch_o_q;

endmodule

// File: doc/ahb_sync_mc.md
# ahb_sync_mc

Multi-channel, parametrised register-handoff synchroniser for the AHB-side configuration path. Each channel is a four-phase req/ack handshake from a foreign clock domain. The block:
- synchronises each `req` through a configurable flop chain;
- captures that channel's DADR/CADR/DLEN on the synchronised request;
- returns a level `ack`;
- queues the captured set;
- presents captured sets one at a time, round-robin, on a single valid/take output port in the HCLK domain.

## Interface
- `NUM_CH`, 4: number of request channels (≥1).
- `ADDR_WIDTH`, 6: width of DADR/CADR per channel.
- `DLEN_WIDTH`, 2: width of DLEN per channel.
- `SYNC_STAGES`, 2: synchroniser depth N (≥2).
- `CH_W`, derived: max(1, clog2(NUM_CH)). Not user-set.

Ports:
- `HCLK` in 1: sole clock, rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `req` in NUM_CH: per-channel request level, asynchronous to HCLK.
- `DADR` in NUM_CH*ADDR_WIDTH: channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `CADR` in NUM_CH*ADDR_WIDTH: same packing as DADR.
- `DLEN` in NUM_CH*DLEN_WIDTH: channel i at [i*DLEN_WIDTH +: DLEN_WIDTH].
- `ack` out NUM_CH: per-channel level acknowledge, registered.
- `REGs_ready` out 1: output set valid.
- `regs_take` in 1: downstream accepts the current output set.
- `DADR_O` out ADDR_WIDTH: granted DADR.
- `CADR_O` out ADDR_WIDTH: granted CADR.
- `DLEN_O` out DLEN_WIDTH: granted DLEN.
- `CH_O` out CH_W: index of the granted channel.

## Operation
- **Synchroniser.** Each `req[i]` passes through N flops. Only the last stage, `sreq[i]`, is used.
- **Per-channel FSM**, two states:
  - IDLE: `ack[i]`=0. If `sreq[i]`=1 and `pend[i]`=0: capture the channel's DADR/CADR/DLEN into holding slot i, set `pend[i]`=1, set `ack[i]`=1, go to ACKD. If `sreq[i]`=1 and `pend[i]`=1: stay in IDLE with `ack` low (capture stalls until the slot drains).
  - ACKD: `ack[i]`=1. When `sreq[i]`=0: `ack[i]`←0, go to IDLE.
- **Requester protocol (fixed).**
  - Hold fields stable from `req` rise until `ack` is seen high.
  - Drop `req` only after `ack` is high.
  - Raise `req` again only after `ack` is low.
- **Capture is synchronous.** There are no latches. Fields are sampled on the capture edge.
- **Output stage.** `REGs_ready` plus a single output register set.
- **Load condition:** (`REGs_ready`=0 or `regs_take`=1) and any `pend` is set.
  - Choose the first pending channel at or after `rr_ptr`, wrapping modulo NUM_CH.
  - Load DADR_O/CADR_O/DLEN_O/CH_O from that slot, clear its `pend`, set `REGs_ready`=1, set `rr_ptr` to grant+1 mod NUM_CH.
- If `regs_take`=1 and nothing is pending: `REGs_ready`←0. Outputs hold their last values.
- If `REGs_ready`=1 and `regs_take`=0: outputs and `REGs_ready` hold. Pending slots wait.
- **Same-cycle events.**
  - Capture into slot i and grant of slot i in the same cycle cannot occur. The grant only sees `pend` set on the cycle after capture.
  - Capture into slot j while slot i is granted are independent.
  - Grant clearing `pend[i]` on the cycle `sreq[i]` is high in IDLE: capture occurs on the following edge.

## Timing
- **Reset** (HRESETn low, async): all sync flops, `pend`, FSMs (IDLE), and `rr_ptr` go to 0. Outputs during and after reset: `ack`=0, `REGs_ready`=0, DADR_O/CADR_O/DLEN_O/CH_O=0.
- **Reset mid-operation:** all captured-but-untaken sets are discarded. After release, a still-high `req` is treated as a new request.
- **Edge numbering.** Edge 1 is the first HCLK edge sampling `req[i]`=1.
  - `sreq` goes high after edge N.
  - Capture and `ack[i]`=1 after edge N+1, if the slot is free.
  - `REGs_ready`=1 with channel i's data after edge N+2, if the output is free and i wins arbitration.
- **Release:** with edge 1 sampling `req[i]`=0, `ack[i]` goes low after edge N+1.
- **Throughput:** one output set per cycle while `regs_take` is held 1 and slots are pending.

## Test plan
- **Single-channel latency.** N=2, ch0 `req` rises with DADR=0x15, CADR=0x2A, DLEN=2, `regs_take`=1. Expect `ack[0]` high after edge 3. Expect `REGs_ready`=1 with 0x15/0x2A/2 and CH_O=0 after edge 4, then `REGs_ready`=0 next cycle.
- **Round-robin.** All 4 channels request on the same cycle with distinct fields, `regs_take`=1. Expect outputs in order ch0, ch1, ch2, ch3 on consecutive cycles. A second burst after `rr_ptr` has moved starts from the next channel.
- **Backpressure.** `regs_take`=0 with ch1 and ch2 captured. Expect the outputs to show ch1 and hold stable for 10 cycles, `pend[2]` to stay set, and ch2 to appear the cycle after `regs_take` rises.
- **Slot stall.** ch0 is captured and completes the 4-phase handshake, then re-requests while still pending (`regs_take`=0). Expect `ack[0]` to stay low. Expect capture of the new fields and `ack[0]` high one edge after the old set is granted.
- **Four-phase release.** Drop `req[0]` after `ack[0]`=1. Expect `ack[0]` low exactly N+1 edges later. Expect no second capture.
- **Async reset.** Assert HRESETn low mid-burst, off a clock edge. Expect `ack`, `REGs_ready`, and all outputs 0 immediately. A held-high `req` is recaptured N+1 edges after release.
